// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
//   Handshake bundle between the ALU result FIFO and its environment.
//   The "slave" modport is the FIFO's view: it accepts pushes on in_*, serves
//   the head on out_* and reports count/overflow. The "master" modport is the
//   environment's view: it drives in_* and out_ready and observes the rest.
//
//   Signals
//     clr         sync clear (empties FIFO, clears overflow)
//     in_valid    upstream result valid
//     in_ready    FIFO can accept (= !full)
//     in_result   ALU result word
//     in_carry    ALU carry flag
//     out_valid   head entry valid (= !empty)
//     out_ready   consumer takes the head this cycle
//     out_result  head result (0 while empty)
//     out_carry   head carry flag (0 while empty)
//     out_zero    head result == 0, captured at push (0 while empty)
//     count       number of stored entries
//     overflow    sticky: a word was offered while full and dropped
//     parity_err  only when ALU_FIFO_PARITY_EN is defined
// ---------------------------------------------------------------------------
interface alu_result_fifo_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;
  logic              out_zero;
  logic [CNT_W-1:0]  count;
  logic              overflow;
`ifdef ALU_FIFO_PARITY_EN
  logic              parity_err;

  modport slave (
    input  clr, in_valid, in_result, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero,
           count, overflow, parity_err
  );

  modport master (
    output clr, in_valid, in_result, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero,
           count, overflow, parity_err
  );
`else
  modport slave (
    input  clr, in_valid, in_result, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero,
           count, overflow
  );

  modport master (
    output clr, in_valid, in_result, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero,
           count, overflow
  );
`endif
endinterface

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   Capture stage behind the combinational ALU. Each accepted result is stored
//   with its carry flag and a zero flag computed at push time, in a small
//   first-word-fall-through FIFO read out over a valid/ready handshake.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   alu_result_fifo_if.slave (see interface file for signal list)
//
//   Parameters
//     DATA_W  result word width
//     DEPTH   number of entries, power of two, >= 2
//     CNT_W   count width, $clog2(DEPTH)+1
//
//   Optional feature
//     ALU_FIFO_PARITY_EN  when defined, each entry also stores the even parity
//                         of {carry,result}; bus.parity_err flags a head entry
//                         whose recomputed parity disagrees with the stored bit.
//
//   Notes
//     - in_ready, out_valid and count come only from registered state; there
//       is no combinational path from in_valid or out_ready to any output.
//     - When full, in_ready stays low even if the head is popped that cycle.
//     - clr wins over push and pop; a push offered during clr is discarded and
//       does not set overflow.
// ---------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_fifo_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic [DATA_W-1:0] mem_result [DEPTH];
  logic              mem_carry  [DEPTH];
  logic              mem_zero   [DEPTH];
`ifdef ALU_FIFO_PARITY_EN
  logic              mem_parity [DEPTH];
`endif

  // -------------------------------------------------------------------------
  // Status decoded from registered count only
  // -------------------------------------------------------------------------
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Handshakes qualify against registered full/empty, so the pop in a full
  // cycle cannot open a slot for a same-cycle push.
  assign push = bus.in_valid  & ~full  & ~bus.clr;
  assign pop  = bus.out_ready & ~empty & ~bus.clr;

  // -------------------------------------------------------------------------
  // Pointers, count, overflow
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      // A word offered while full is dropped; remember it until clr/rst.
      if (bus.in_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; unread slots are never observable
  // because the head outputs are masked while empty, and leaving it out of
  // reset lets it map onto plain flops/LUT RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= bus.in_result;
      mem_carry[wr_ptr]  <= bus.in_carry;
      mem_zero[wr_ptr]   <= (bus.in_result == '0);
`ifdef ALU_FIFO_PARITY_EN
      mem_parity[wr_ptr] <= ^{bus.in_carry, bus.in_result};
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Head presentation (first-word fall-through)
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] head_result;
  logic              head_carry;
  logic              head_zero;

  // NOTE: every signal written in always_comb is given a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    head_result = '0;
    head_carry  = 1'b0;
    head_zero   = 1'b0;
    if (!empty) begin
      head_result = mem_result[rd_ptr];
      head_carry  = mem_carry[rd_ptr];
      head_zero   = mem_zero[rd_ptr];
    end
  end

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_result = head_result;
  assign bus.out_carry  = head_carry;
  assign bus.out_zero   = head_zero;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;

`ifdef ALU_FIFO_PARITY_EN
  // Recompute parity on the stored head and compare with the bit captured at
  // push; a disagreement means the entry was corrupted while resident.
  logic head_parity_err;

  always_comb begin
    head_parity_err = 1'b0;
    if (!empty) begin
      head_parity_err = (^{mem_carry[rd_ptr], mem_result[rd_ptr]}) != mem_parity[rd_ptr];
    end
  end

  assign bus.parity_err = head_parity_err;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
//   Self-checking bench for alu_result_fifo. A queue holds the entries the
//   FIFO should contain; every accepted push appends the expected entry and
//   every pop compares the DUT head against the front of the queue.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              zero;
  } entry_t;

  logic clk;
  logic rst;

  alu_result_fifo_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  alu_result_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t sb[$];
  logic   exp_overflow;
  int     n_tests;
  int     n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Status as seen after an edge, plus masked data while empty.
  task automatic check_state(input string tag);
    check({tag, ".count"},     32'(bus.count),     32'(sb.size()));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(sb.size() != 0));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(sb.size() != DEPTH));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(exp_overflow));
    if (sb.size() == 0) begin
      check({tag, ".empty_data"},
            32'({bus.out_result, bus.out_carry, bus.out_zero}), 32'(0));
    end
`ifdef ALU_FIFO_PARITY_EN
    check({tag, ".parity_err"}, 32'(bus.parity_err), 32'(0));
`endif
  endtask

  // One clock cycle: drive inputs after the falling edge, score the pop
  // against the head before the rising edge, update the model, then check
  // status just after the rising edge.
  task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] r,
                       input logic c, input logic ordy, input logic clr_i);
    entry_t e;
    entry_t head;
    bit     full_now;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_carry  = c;
    bus.out_ready = ordy;
    bus.clr       = clr_i;
    #1;
    full_now = (sb.size() == DEPTH);
    if (clr_i) begin
      sb.delete();
      exp_overflow = 1'b0;
    end else begin
      if (ordy && sb.size() != 0) begin
        head = sb.pop_front();
        check({tag, ".result"}, 32'(bus.out_result), 32'(head.result));
        check({tag, ".carry"},  32'(bus.out_carry),  32'(head.carry));
        check({tag, ".zero"},   32'(bus.out_zero),   32'(head.zero));
      end
      if (v && full_now) begin
        exp_overflow = 1'b1;
      end else if (v) begin
        e.result = r;
        e.carry  = c;
        e.zero   = (r == 0);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    exp_overflow = 1'b0;
    rst           = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_carry  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;

    // 1: single word, fall-through latency of one edge, then pop.
    cycle("t1_push", 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0);
    check("t1_head_result", 32'(bus.out_result), 32'h2A);
    check("t1_head_zero",   32'(bus.out_zero),   32'(0));
    cycle("t1_pop", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // 2: three words with consumer stalled, then drained in order.
    cycle("t2_push0", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle("t2_push1", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    cycle("t2_push2", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle("t2_pop", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // 3: fill, offer 0x55 while full (dropped), drain, overflow stays sticky.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("t3_fill", 1'b1, 8'(8'hA0 + i), i[0], 1'b0, 1'b0);
    end
    repeat (2) cycle("t3_ovf", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    // Full with out_ready high: the pop happens but the push is still refused.
    cycle("t3_full_pop", 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    repeat (DEPTH) cycle("t3_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle("t3_sticky");
    cycle("t3_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // 4: hold count at two with simultaneous push/pop across pointer wraps.
    cycle("t4_pre0", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cycle("t4_pre1", 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("t4_pp", 1'b1, 8'(8'h30 + i), i[1], 1'b1, 1'b0);
    end
    repeat (2) cycle("t4_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // 5a: clr with a concurrent push discards it and does not set overflow.
    for (int i = 0; i < 3; i++) begin
      cycle("t5_fill", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    end
    cycle("t5_clr", 1'b1, 8'h99, 1'b1, 1'b0, 1'b1);

    // 5b: asynchronous reset mid-stream after forcing overflow.
    for (int i = 0; i < DEPTH + 1; i++) begin
      cycle("t5_fill2", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.clr      = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    exp_overflow = 1'b0;
    check_state("t5_async_rst");
    @(negedge clk);
    rst = 1'b0;
    check_state("t5_after_rst");

    // Random traffic with occasional clr.
    for (int i = 0; i < 80; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
            $urandom_range(0, 15) == 0);
    end
    repeat (DEPTH) cycle("final_drain", 1'b0, '0, 1'b0, 1'b1, 1'b0);

`ifdef ALU_FIFO_PARITY_EN
    // 6: corrupt the stored parity of a resident head and expect an error.
    cycle("t6_push", 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    dut.mem_parity[dut.rd_ptr] = ~dut.mem_parity[dut.rd_ptr];
    #1;
    n_tests++;
    if (bus.parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_parity_err: got %0b expected 1", bus.parity_err);
    end
    cycle("t6_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
